// File: rtl/deck_dealer.sv
// 52-card deck: Fisher-Yates shuffle driven by a Galois LFSR with rejection sampling,
// then streams the shuffled cards one per handshake over valid/ready.
package deck_dealer_pkg;
  typedef struct packed {
    logic [1:0] suit;
    logic [3:0] rank;
  } card_t;
endpackage

module deck_dealer
  import deck_dealer_pkg::*;
#(
  parameter int                DECK_SIZE = 52,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED_RST  = 16'hACE1,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              shuffle_start,
  output logic              shuffle_busy,
  output logic              card_valid,
  input  logic              card_ready,
  output card_t             card_out,
  output logic [5:0]        card_idx,
  output logic [5:0]        cards_left
);

  typedef enum logic [1:0] {IDLE, INIT, SHUFFLE, READY} state_t;

  state_t            state, state_next;
  logic [LFSR_W-1:0] lfsr, lfsr_next;
  logic [5:0]        deck [DECK_SIZE];
  logic [5:0]        i_idx;
  logic [5:0]        ptr;
  logic [5:0]        rand_idx;
  logic              draw_ok;
  logic              last_swap;
  logic              handshake;

  // Draws above the current top-of-unshuffled index are rejected and retried next cycle.
  always_comb begin
    rand_idx  = lfsr[5:0];
    draw_ok   = (rand_idx <= i_idx);
    last_swap = draw_ok && (i_idx == 6'd1);
    handshake = card_valid && card_ready;
  end

  always_comb begin
    if (seed_load)
      lfsr_next = (seed_in == '0) ? LFSR_W'(1) : seed_in;
    else if (lfsr[0])
      lfsr_next = (lfsr >> 1) ^ LFSR_TAPS;
    else
      lfsr_next = lfsr >> 1;
  end

  always_comb begin
    state_next   = state;
    shuffle_busy = 1'b0;
    card_valid   = 1'b0;
    unique case (state)
      IDLE: ;
      INIT: begin
        shuffle_busy = 1'b1;
        state_next   = SHUFFLE;
      end
      SHUFFLE: begin
        shuffle_busy = 1'b1;
        if (last_swap)
          state_next = READY;
      end
      READY: card_valid = (cards_left != 6'd0);
      default: state_next = IDLE;
    endcase
    if (shuffle_start)
      state_next = INIT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      lfsr  <= SEED_RST;
    end else begin
      state <= state_next;
      lfsr  <= lfsr_next;
    end
  end

  // A handshake coinciding with shuffle_start still retires its card before INIT clears the deck.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DECK_SIZE; k++)
        deck[k] <= 6'(k);
      i_idx      <= '0;
      ptr        <= '0;
      cards_left <= '0;
    end else begin
      unique case (state)
        INIT: begin
          for (int k = 0; k < DECK_SIZE; k++)
            deck[k] <= 6'(k);
          i_idx      <= 6'(DECK_SIZE - 1);
          ptr        <= '0;
          cards_left <= '0;
        end
        SHUFFLE: begin
          if (draw_ok) begin
            deck[i_idx]    <= deck[rand_idx];
            deck[rand_idx] <= deck[i_idx];
            i_idx          <= i_idx - 6'd1;
            if (last_swap) begin
              ptr        <= '0;
              cards_left <= 6'(DECK_SIZE);
            end
          end
        end
        READY: begin
          if (handshake) begin
            cards_left <= cards_left - 6'd1;
            if (cards_left != 6'd1)
              ptr <= ptr + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    card_idx = deck[ptr];
    if (card_idx >= 6'd39) begin
      card_out.suit = 2'd3;
      card_out.rank = 4'(card_idx - 6'd39);
    end else if (card_idx >= 6'd26) begin
      card_out.suit = 2'd2;
      card_out.rank = 4'(card_idx - 6'd26);
    end else if (card_idx >= 6'd13) begin
      card_out.suit = 2'd1;
      card_out.rank = 4'(card_idx - 6'd13);
    end else begin
      card_out.suit = 2'd0;
      card_out.rank = card_idx[3:0];
    end
  end

endmodule

// File: tb/tb_deck_dealer.sv
// Self-checking bench for deck_dealer: a scoreboard fed by a Fisher-Yates reference model,
// drained by a monitor that checks every accepted card.
module tb_deck_dealer;
  import deck_dealer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = '0;
  logic        shuffle_start = 1'b0;
  logic        card_ready = 1'b0;
  logic        shuffle_busy;
  logic        card_valid;
  card_t       card_out;
  logic [5:0]  card_idx;
  logic [5:0]  cards_left;

  int total = 0;
  int bad = 0;
  int exp_q[$];
  int dealt[$];
  int seq_a[$];
  int seq_b[$];
  int deal_count = 0;
  logic       hold_valid = 1'b0;
  logic [5:0] hold_idx = '0;

  deck_dealer dut (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
    .shuffle_start(shuffle_start), .shuffle_busy(shuffle_busy),
    .card_valid(card_valid), .card_ready(card_ready), .card_out(card_out),
    .card_idx(card_idx), .cards_left(cards_left)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  function automatic logic [15:0] lfsr_advance(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference: textbook Fisher-Yates from the top index down, one LFSR draw per attempt.
  task automatic model_shuffle(input logic [15:0] seed);
    int deck[52];
    logic [15:0] l;
    int i, r, t, guard;
    l = (seed == 16'h0) ? 16'h1 : seed;
    for (int k = 0; k < 52; k++) deck[k] = k;
    i = 51;
    guard = 0;
    while (i > 0 && guard < 100000) begin
      l = lfsr_advance(l);
      r = int'(l[5:0]);
      if (r <= i) begin
        t = deck[i]; deck[i] = deck[r]; deck[r] = t;
        i--;
      end
      guard++;
    end
    exp_q.delete();
    for (int k = 0; k < 52; k++) exp_q.push_back(deck[k]);
  endtask

  // Monitor: samples on the falling edge; a valid&ready seen here is accepted at the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      if (hold_valid && card_valid)
        checkOutput("stall_stable", 64'(card_idx), 64'(hold_idx));
      hold_valid = card_valid && !card_ready;
      hold_idx   = card_idx;
      if (card_valid && card_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("extra_card", 64'(1), 64'(0));
        end else begin
          int e;
          logic [5:0] exp_card;
          checkOutput("cards_left", 64'(cards_left), 64'(exp_q.size()));
          e = exp_q.pop_front();
          exp_card = {2'(e / 13), 4'(e % 13)};
          checkOutput("card_idx", 64'(card_idx), 64'(e));
          checkOutput("card_out", 64'(card_out), 64'(exp_card));
          dealt.push_back(int'(card_idx));
          deal_count++;
        end
      end
    end else begin
      hold_valid = 1'b0;
    end
  end

  task automatic applyStimulus(input logic [15:0] s);
    seed_in       = s;
    seed_load     = 1'b1;
    shuffle_start = 1'b1;
    @(posedge clk);
    model_shuffle(s);
    #1;
    seed_load     = 1'b0;
    shuffle_start = 1'b0;
  endtask

  task automatic wait_valid();
    for (int c = 0; c < 2000; c++) begin
      if (card_valid) break;
      @(posedge clk); #1;
    end
    checkOutput("shuffle_timeout", 64'(card_valid), 64'(1));
  endtask

  task automatic wait_deals(input int n, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (deal_count >= n) break;
      @(posedge clk); #1;
    end
    checkOutput("deal_timeout", 64'(deal_count >= n), 64'(1));
  endtask

  task automatic check_perm(input string name);
    logic [63:0] mask;
    mask = '0;
    foreach (dealt[k]) mask[dealt[k]] = 1'b1;
    checkOutput({name, "_count"}, 64'(dealt.size()), 64'(52));
    checkOutput({name, "_cover"}, mask, 64'h000F_FFFF_FFFF_FFFF);
  endtask

  task automatic full_deal(input logic [15:0] s);
    dealt.delete();
    deal_count = 0;
    card_ready = 1'b1;
    applyStimulus(s);
    checkOutput("busy_init", 64'(shuffle_busy), 64'(1));
    wait_valid();
    checkOutput("left_full", 64'(cards_left), 64'(52));
    wait_deals(52, 200);
    checkOutput("left_empty", 64'(cards_left), 64'(0));
    check_perm("perm");
  endtask

  function automatic int seq_diff(input int a[$], input int b[$]);
    int d;
    d = (a.size() == b.size()) ? 0 : 1;
    for (int k = 0; k < a.size() && k < b.size(); k++)
      if (a[k] != b[k]) d++;
    return d;
  endfunction

  initial begin
    int base;
    // Reset held low for three cycles.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 64'(card_valid), 64'(0));
    checkOutput("rst_busy", 64'(shuffle_busy), 64'(0));
    checkOutput("rst_left", 64'(cards_left), 64'(0));
    checkOutput("rst_idx", 64'(card_idx), 64'(0));
    reset = 1'b1;
    card_ready = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    checkOutput("idle_valid", 64'(card_valid), 64'(0));

    // Seeded shuffle and full deal, then determinism checks.
    full_deal(16'h1234);
    seq_a = dealt;
    full_deal(16'h1234);
    checkOutput("repeat_seq", 64'(seq_diff(seq_a, dealt)), 64'(0));
    full_deal(16'h0001);
    seq_b = dealt;
    full_deal(16'h0000);
    checkOutput("seed0_seq", 64'(seq_diff(seq_b, dealt)), 64'(0));

    // Stall after five cards.
    card_ready = 1'b0;
    dealt.delete();
    deal_count = 0;
    applyStimulus(16'($urandom));
    wait_valid();
    card_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 card_ready = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    checkOutput("stall_left", 64'(cards_left), 64'(47));
    checkOutput("stall_count", 64'(deal_count), 64'(5));
    checkOutput("stall_valid", 64'(card_valid), 64'(1));

    // Reshuffle mid-deal after twenty cards; the coinciding handshake still completes.
    card_ready = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    applyStimulus(16'($urandom));
    checkOutput("valid_drop", 64'(card_valid), 64'(0));
    checkOutput("mid_count", 64'(deal_count), 64'(21));
    dealt.delete();
    card_ready = 1'b0;
    wait_valid();
    checkOutput("reshuf_left", 64'(cards_left), 64'(52));
    for (int c = 0; c < 2000 && dealt.size() < 52; c++) begin
      card_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    check_perm("reshuf");

    // Exhausted deck with ready held high.
    base = deal_count;
    card_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    checkOutput("empty_valid", 64'(card_valid), 64'(0));
    checkOutput("empty_left", 64'(cards_left), 64'(0));
    checkOutput("empty_count", 64'(deal_count), 64'(base));

    // Reset in the middle of a shuffle.
    applyStimulus(16'hBEEF);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("midrst_busy", 64'(shuffle_busy), 64'(0));
    checkOutput("midrst_left", 64'(cards_left), 64'(0));
    checkOutput("midrst_valid", 64'(card_valid), 64'(0));
    reset = 1'b1;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
